// File: rtl/msp_pkg.sv
// Shared encodings for the memory bus arbiter: FSM states, grant codes and
// address alignment.
package msp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_ACK  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    GNT_NONE  = 2'd0,
    GNT_FETCH = 2'd1,
    GNT_OPND  = 2'd2,
    GNT_WB    = 2'd3
  } gnt_e;

  // Word accesses are forced even; byte accesses keep the exact address.
  function automatic logic [15:0] align_addr(input logic [15:0] addr, input logic bw);
    return bw ? addr : {addr[15:1], 1'b0};
  endfunction

endpackage

// File: rtl/arb_prio.sv
// Combinational 3-way fixed-priority picker (wb > opnd > fetch) with a
// starvation override that hands the bus to fetch.
module arb_prio
  import msp_pkg::*;
(
  input  logic fetch_req,
  input  logic opnd_req,
  input  logic wb_req,
  input  logic starve_ovr,
  output gnt_e winner
);

  always_comb begin
    winner = GNT_NONE;
    if (starve_ovr && fetch_req) winner = GNT_FETCH;
    else if (wb_req)             winner = GNT_WB;
    else if (opnd_req)           winner = GNT_OPND;
    else if (fetch_req)          winner = GNT_FETCH;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the single mem_space port between fetch, operand read and write-back,
// sequencing each access and returning a one-cycle ack to the owner.
module mem_bus_arbiter
  import msp_pkg::*;
#(
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned WR_TIMEOUT = 8,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req,
  input  logic [15:0] fetch_addr,
  output logic        fetch_ack,
  output logic [15:0] fetch_data,
  input  logic        opnd_req,
  input  logic [15:0] opnd_addr,
  input  logic        opnd_bw,
  output logic        opnd_ack,
  output logic [15:0] opnd_data,
  input  logic        wb_req,
  input  logic [15:0] wb_addr,
  input  logic [15:0] wb_data,
  input  logic        wb_bw,
  output logic        wb_ack,
  output logic [15:0] MAB_in,
  output logic [15:0] MDB_in,
  output logic        MW,
  output logic        BW,
  input  logic [15:0] MDB_out,
  input  logic        ram_write_done,
  output logic [1:0]  grant,
  output logic        wr_timeout_err
);

  localparam int unsigned CNT_MAX = (RD_LAT > WR_TIMEOUT) ? RD_LAT : WR_TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned SW      = $clog2(STARVE_LIM + 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_TIMEOUT - 1);
  localparam logic [SW-1:0]    S_LIM   = SW'(STARVE_LIM);

  state_e          state_q, state_d;
  gnt_e            owner_q, owner_d;
  gnt_e            winner;
  logic [15:0]     addr_q, addr_d;
  logic [15:0]     wdata_q, wdata_d;
  logic            bw_q, bw_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic [15:0]     fdata_q, fdata_d;
  logic [15:0]     odata_q, odata_d;
  logic            err_q, err_d;
  logic [15:0]     rdata;

  arb_prio u_arb_prio (
    .fetch_req  (fetch_req),
    .opnd_req   (opnd_req),
    .wb_req     (wb_req),
    .starve_ovr (starve_q == S_LIM),
    .winner     (winner)
  );

  assign rdata = bw_q ? {8'h00, MDB_out[7:0]} : MDB_out;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    bw_d     = bw_q;
    cnt_d    = cnt_q;
    starve_d = starve_q;
    fdata_d  = fdata_q;
    odata_d  = odata_q;
    err_d    = err_q;

    // Starvation count only advances on an IDLE arbitration fetch loses.
    if (!fetch_req || (state_q == ST_IDLE && winner == GNT_FETCH)) starve_d = '0;
    else if (state_q == ST_IDLE && starve_q != S_LIM)              starve_d = starve_q + 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d   = '0;
        owner_d = winner;
        unique case (winner)
          GNT_FETCH: begin
            addr_d  = align_addr(fetch_addr, 1'b0);
            bw_d    = 1'b0;
            state_d = ST_RD;
          end
          GNT_OPND: begin
            addr_d  = align_addr(opnd_addr, opnd_bw);
            bw_d    = opnd_bw;
            state_d = ST_RD;
          end
          GNT_WB: begin
            addr_d  = align_addr(wb_addr, wb_bw);
            bw_d    = wb_bw;
            wdata_d = wb_data;
            state_d = ST_WR;
          end
          default: state_d = ST_IDLE;
        endcase
      end
      ST_RD: begin
        if (cnt_q == RD_LAST) begin
          if (owner_q == GNT_FETCH) fdata_d = rdata;
          else                      odata_d = rdata;
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WR: begin
        if (ram_write_done) begin
          state_d = ST_ACK;
        end else if (cnt_q == WR_LAST) begin
          err_d   = 1'b1;
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= GNT_NONE;
      addr_q   <= '0;
      wdata_q  <= '0;
      bw_q     <= 1'b0;
      cnt_q    <= '0;
      starve_q <= '0;
      fdata_q  <= '0;
      odata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      bw_q     <= bw_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      fdata_q  <= fdata_d;
      odata_q  <= odata_d;
      err_q    <= err_d;
    end
  end

  assign MAB_in         = addr_q;
  assign MDB_in         = wdata_q;
  assign BW             = bw_q;
  assign MW             = (state_q == ST_WR);
  assign grant          = (state_q == ST_RD || state_q == ST_WR) ? owner_q : GNT_NONE;
  assign fetch_ack      = (state_q == ST_ACK) && (owner_q == GNT_FETCH);
  assign opnd_ack       = (state_q == ST_ACK) && (owner_q == GNT_OPND);
  assign wb_ack         = (state_q == ST_ACK) && (owner_q == GNT_WB);
  assign fetch_data     = fdata_q;
  assign opnd_data      = odata_q;
  assign wr_timeout_err = err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: table of single accesses plus
// hand-written reset, contention, timeout and abort sequences.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req, opnd_req, opnd_bw, wb_req, wb_bw;
  logic [15:0] fetch_addr, opnd_addr, wb_addr, wb_data;
  logic        fetch_ack, opnd_ack, wb_ack;
  logic [15:0] fetch_data, opnd_data;
  logic [15:0] MAB_in, MDB_in, MDB_out;
  logic        MW, BW, ram_write_done;
  logic [1:0]  grant;
  logic        wr_timeout_err;

  int total = 0;
  int bad   = 0;

  mem_bus_arbiter #(.RD_LAT(1), .WR_TIMEOUT(8), .STARVE_LIM(4)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack), .fetch_data(fetch_data),
    .opnd_req(opnd_req), .opnd_addr(opnd_addr), .opnd_bw(opnd_bw), .opnd_ack(opnd_ack), .opnd_data(opnd_data),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data), .wb_bw(wb_bw), .wb_ack(wb_ack),
    .MAB_in(MAB_in), .MDB_in(MDB_in), .MW(MW), .BW(BW), .MDB_out(MDB_out),
    .ram_write_done(ram_write_done), .grant(grant), .wr_timeout_err(wr_timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  kind;     // 1 fetch, 2 opnd, 3 wb
    logic [15:0] addr;
    logic        bw;
    logic [15:0] wdata;
    logic [15:0] mdb;
    int          dly;      // write: WR cycle on which ram_write_done rises
    logic [15:0] exp_mab;
    logic        exp_bw;
    logic [15:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_all();
    fetch_req = 1'b0; opnd_req = 1'b0; wb_req = 1'b0; ram_write_done = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int lat, wrk;
    bit seen, acked;
    logic [2:0] exp_acks;
    lat = 1; wrk = 0; seen = 0; acked = 0;
    MDB_out = v.mdb;
    ram_write_done = 1'b0;
    case (v.kind)
      2'd1: begin fetch_addr = v.addr; fetch_req = 1'b1; end
      2'd2: begin opnd_addr = v.addr; opnd_bw = v.bw; opnd_req = 1'b1; end
      default: begin wb_addr = v.addr; wb_bw = v.bw; wb_data = v.wdata; wb_req = 1'b1; end
    endcase
    exp_acks = (v.kind == 2'd1) ? 3'b100 : (v.kind == 2'd2) ? 3'b010 : 3'b001;
    for (int c = 0; c < 40 && !acked; c++) begin
      tick();
      lat++;
      if (grant != 2'd0 && !seen) begin
        seen = 1;
        chk("vec_grant", grant, v.kind);
        chk("vec_mab", MAB_in, v.exp_mab);
        chk("vec_bw", BW, v.exp_bw);
        chk("vec_mw", MW, v.kind == 2'd3);
        if (v.kind == 2'd3) chk("vec_mdb_in", MDB_in, v.wdata);
      end
      if (MW) begin
        wrk++;
        if (wrk == v.dly) ram_write_done = 1'b1;
      end
      if (fetch_ack || opnd_ack || wb_ack) begin
        acked = 1;
        chk("vec_ack_sel", {fetch_ack, opnd_ack, wb_ack}, exp_acks);
        chk("vec_latency", lat, v.exp_lat);
        chk("vec_ack_grant", grant, 0);
        chk("vec_ack_mw", MW, 0);
        if (v.kind == 2'd1) chk("vec_fetch_data", fetch_data, v.exp_data);
        if (v.kind == 2'd2) chk("vec_opnd_data", opnd_data, v.exp_data);
        drop_all();
      end
    end
    chk("vec_acked", acked, 1);
    drop_all();
    tick();
  endtask

  initial begin
    int cnt;
    bit found;
    logic [1:0] exp_order[8];
    logic [1:0] g;

    vecs[0] = '{2'd1, 16'hF801, 1'b0, 16'h0000, 16'h4031, 0, 16'hF800, 1'b0, 16'h4031, 3};
    vecs[1] = '{2'd2, 16'h0201, 1'b1, 16'h0000, 16'hABCD, 0, 16'h0201, 1'b1, 16'h00CD, 3};
    vecs[2] = '{2'd2, 16'h0201, 1'b0, 16'h0000, 16'hABCD, 0, 16'h0200, 1'b0, 16'hABCD, 3};
    vecs[3] = '{2'd3, 16'h1235, 1'b0, 16'hBEEF, 16'h0000, 1, 16'h1234, 1'b0, 16'h0000, 3};
    vecs[4] = '{2'd3, 16'h1235, 1'b1, 16'h00A5, 16'h0000, 3, 16'h1235, 1'b1, 16'h0000, 5};
    vecs[5] = '{2'd1, 16'h7FFF, 1'b0, 16'h0000, 16'h55AA, 0, 16'h7FFE, 1'b0, 16'h55AA, 3};
    vecs[6] = '{2'd2, 16'hFFFF, 1'b1, 16'h0000, 16'h12FE, 0, 16'hFFFF, 1'b1, 16'h00FE, 3};
    exp_order = '{2'd3, 2'd2, 2'd3, 2'd2, 2'd1, 2'd3, 2'd2, 2'd3};

    rst = 1'b0;
    drop_all();
    fetch_addr = '0; opnd_addr = '0; opnd_bw = 1'b0;
    wb_addr = '0; wb_data = '0; wb_bw = 1'b0; MDB_out = '0;
    #3;
    chk("reset_outputs",
        {fetch_ack, opnd_ack, wb_ack, MW, BW, grant, wr_timeout_err, MAB_in, MDB_in}, '0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // Reset in the middle of a write drops MW at once and issues no ack.
    wb_addr = 16'h0100; wb_data = 16'h1234; wb_bw = 1'b0; wb_req = 1'b1;
    tick();
    chk("rst_pre_mw", MW, 1);
    #2 rst = 1'b0;
    #1;
    chk("rst_mw_async", MW, 0);
    chk("rst_grant", grant, 0);
    drop_all();
    tick();
    rst = 1'b1;
    cnt = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (fetch_ack || opnd_ack || wb_ack) cnt++;
    end
    chk("rst_no_ack", cnt, 0);
    chk("rst_err_clear", wr_timeout_err, 0);

    foreach (vecs[i]) run_vec(vecs[i]);
    chk("fetch_data_stable", fetch_data, 16'h55AA);

    // Contention: every requester drops req for the arbitration right after its ack.
    ram_write_done = 1'b1;
    fetch_addr = 16'h0010; opnd_addr = 16'h0020; wb_addr = 16'h0030; MDB_out = 16'h0F0F;
    fetch_req = 1'b1; opnd_req = 1'b1; wb_req = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) begin
      chk("cont_grant", grant, exp_order[k]);
      g = grant;
      found = 0;
      for (int c = 0; c < 20 && !found; c++) begin
        if ((g == 2'd1 && fetch_ack) || (g == 2'd2 && opnd_ack) || (g == 2'd3 && wb_ack)) found = 1;
        else tick();
      end
      chk("cont_ack_seen", found, 1);
      if (g == 2'd1) fetch_req = 1'b0;
      if (g == 2'd2) opnd_req = 1'b0;
      if (g == 2'd3) wb_req = 1'b0;
      tick(); tick();
      if (g == 2'd1) fetch_req = 1'b1;
      if (g == 2'd2) opnd_req = 1'b1;
      if (g == 2'd3) wb_req = 1'b1;
    end
    drop_all();
    for (int c = 0; c < 4; c++) tick();

    // Write timeout: done never arrives.
    wb_addr = 16'h0400; wb_data = 16'hCAFE; wb_bw = 1'b0; wb_req = 1'b1;
    cnt = 0; found = 0;
    for (int c = 0; c < 30 && !found; c++) begin
      tick();
      if (MW) cnt++;
      if (wb_ack) found = 1;
    end
    chk("to_ack", found, 1);
    chk("to_mw_cycles", cnt, 8);
    chk("to_err_set", wr_timeout_err, 1);
    drop_all();
    tick();

    // Abort: operand requester gives up after grant.
    opnd_addr = 16'h0011; opnd_bw = 1'b0; MDB_out = 16'h1111; opnd_req = 1'b1;
    tick();
    chk("abort_grant", grant, 2);
    opnd_req = 1'b0;
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (opnd_ack) cnt++;
    end
    chk("abort_ack_once", cnt, 1);
    chk("abort_data", opnd_data, 16'h1111);
    fetch_addr = 16'h0020; MDB_out = 16'h2222; fetch_req = 1'b1;
    tick();
    chk("post_abort_grant", grant, 1);
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      tick();
      if (fetch_ack) found = 1;
    end
    chk("post_abort_ack", found, 1);
    chk("post_abort_data", fetch_data, 16'h2222);
    drop_all();
    tick();
    chk("err_sticky", wr_timeout_err, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
